competition_question_bank: RTL and testbench
============================================

Name: competition_question_bank

Overview:
- Parametrised question-entry recorder for competition mode.
- The operator picks a mode (1..5), then an operator index, then keys in operand a and, except in mode 1, operand b. Each completed question is committed into an on-chip bank of DEPTH entries.
- Outputs carry the entry state, current mode, operator and prompt to the display driver. A registered read port lets the answer/check logic fetch stored questions by index.

Parameters:
- DATA_W, 8, operand width in bits.
- DEPTH, 16, number of question entries in the bank (power of two, >= 2).
- IDX_W, $clog2(DEPTH), index width (derived).
- ENTRY_W, 5+2*DATA_W, stored entry width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- confirm  in  1  debounced level button: advance/commit.
- select  in  1  debounced level button: cycle mode or operator.
- exit  in  1  debounced level button: abort to mode selection.
- clr_bank  in  1  debounced level button: empty the bank (honoured in MODE_SEL only).
- in  in  DATA_W  switch operand input.
- rd_idx  in  IDX_W  read index.
- rd_entry  out  ENTRY_W  entry {mode[2:0], op[1:0], a, b}, registered.
- count  out  IDX_W+1  number of stored entries.
- full  out  1  count==DEPTH.
- state  out  2  0 MODE_SEL, 1 OP_SEL, 2 ENTER_A, 3 ENTER_B.
- mode_o  out  3  current mode, 1..5.
- op_o  out  2  current operator index.
- prompt  out  2  00 none, 01 "a", 10 "b".
- commit  out  1  one-cycle pulse: entry written.
- reject  out  1  one-cycle pulse: commit refused, bank full.

Behaviour:
- Reset (async) values:
  - state=MODE_SEL, mode_o=1, op_o=0, prompt=00.
  - count=0, full=0, commit=0, reject=0, rd_entry=0.
  - Edge-detect registers=0.
  - Bank contents are not reset.
- Buttons are rising-edge detected: press = level 1 now and 0 at the previous clock. The resulting action updates registers at that same edge. A held button acts once.
- Same-edge press priority: exit > confirm > select > clr_bank. Only the highest-priority press acts.
- Operator count per mode: mode1=3 (radix b/o/h), mode2=2 (+/-), modes 3..5=4.
- MODE_SEL:
  - select: mode 1->2->3->4->5->1.
  - confirm: op=0, go to OP_SEL.
  - clr_bank: count=0.
- OP_SEL:
  - select: op increments, wrapping to 0 after op count(mode)-1.
  - confirm: go to ENTER_A.
- ENTER_A:
  - confirm latches a=in.
  - Mode 1: commit with b=0, return to OP_SEL.
  - Other modes: go to ENTER_B.
  - select ignored.
- ENTER_B:
  - confirm: commit with b=in, return to OP_SEL.
  - select ignored.
- Commit:
  - If count<DEPTH: bank[count] <= {mode,op,a,b}, count++, commit=1 for one cycle.
  - Else: no write, count unchanged, reject=1 for one cycle.
  - Either way, state returns to OP_SEL and op is held.
- exit in any state: state=MODE_SEL, op=0, partial operand discarded, mode held, count unchanged. In MODE_SEL, exit is a no-op.
- prompt: 01 in ENTER_A, 10 in ENTER_B, otherwise 00.
- full is combinational from count.
- Read port: rd_entry <= (rd_idx<count) ? bank[rd_idx] : 0. Latency is 1 cycle.
  - A read of the index being written in the same cycle returns the old contents (or 0 if that index was >= count).
- Reset mid-entry aborts the entry. count returns to 0, and subsequent reads return 0.

Test Plan:
- Mode cycling: after reset, press select 5 times -> mode_o steps 2,3,4,5,1. Press select and confirm on the same edge -> confirm wins: state=OP_SEL, mode unchanged.
- Mode 1 commit: mode 1, confirm, select×2 (op=2), confirm, in=8'hA5, confirm -> commit pulse, count=1. rd_idx=0 gives {3'd1,2'd2,8'hA5,8'h00} one cycle later; state=OP_SEL.
- Mode 2 op wrap and two-operand commit: mode 2, select×2 in OP_SEL -> op 1 then 0. Then enter a=8'h12, b=8'h34 -> entry {3'd2,2'd0,8'h12,8'h34}.
- Full and reject: commit DEPTH entries -> full=1. Next commit -> reject pulse, count stays DEPTH, bank[DEPTH-1] unchanged.
- Exit and clear: exit in ENTER_B after a latched -> MODE_SEL, count unchanged. clr_bank in OP_SEL is ignored. clr_bank in MODE_SEL -> count=0, rd_entry=0 for index 0.
- Async reset mid-ENTER_B with count=3: outputs go to reset values immediately without a clock edge; rd_entry is 0 for all indices afterwards.

Source files
------------

// File: rtl/competition_question_bank.sv
// Competition question recorder: button-driven mode/op/operand entry, committed into a DEPTH-entry bank.
// Button actions and commits take effect on the press edge; read port is registered (1 cycle), full bank rejects commits.
module competition_question_bank #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int IDX_W   = $clog2(DEPTH),
   parameter int ENTRY_W = 5 + 2*DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               confirm,
   input  logic               select,
   input  logic               exit,
   input  logic               clr_bank,
   input  logic [DATA_W-1:0]  in,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [ENTRY_W-1:0] rd_entry,
   output logic [IDX_W:0]     count,
   output logic               full,
   output logic [1:0]         state,
   output logic [2:0]         mode_o,
   output logic [1:0]         op_o,
   output logic [1:0]         prompt,
   output logic               commit,
   output logic               reject
);

   typedef enum logic [1:0] {
      MODE_SEL = 2'd0,
      OP_SEL   = 2'd1,
      ENTER_A  = 2'd2,
      ENTER_B  = 2'd3
   } state_t;

   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [2:0]          mode_q, mode_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [IDX_W:0]      count_q, count_d;
   logic                commit_q, commit_d;
   logic                reject_q, reject_d;
   logic [3:0]          btn_q;
   logic [ENTRY_W-1:0]  rd_entry_q;
   logic [ENTRY_W-1:0]  bank_q [DEPTH];

   logic [3:0]          btn_now, press;
   logic [1:0]          op_last;
   logic                do_commit, we;
   logic [DATA_W-1:0]   commit_a, commit_b;
   logic [ENTRY_W-1:0]  wdat;

   // bit order: {clr_bank, exit, select, confirm}
   assign btn_now = {clr_bank, exit, select, confirm};
   assign press   = btn_now & ~btn_q;

   always_comb begin
      case (mode_q)
         3'd1:    op_last = 2'd2;
         3'd2:    op_last = 2'd1;
         default: op_last = 2'd3;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      op_d      = op_q;
      a_d       = a_q;
      count_d   = count_q;
      commit_d  = 1'b0;
      reject_d  = 1'b0;
      do_commit = 1'b0;
      we        = 1'b0;
      commit_a  = a_q;
      commit_b  = '0;

      if (press[2]) begin
         if (state_q != MODE_SEL) begin
            state_d = MODE_SEL;
            op_d    = 2'd0;
         end
      end else if (press[0]) begin
         case (state_q)
            MODE_SEL: begin
               op_d    = 2'd0;
               state_d = OP_SEL;
            end
            OP_SEL:   state_d = ENTER_A;
            ENTER_A: begin
               a_d      = in;
               commit_a = in;
               if (mode_q == 3'd1) do_commit = 1'b1;
               else                state_d   = ENTER_B;
            end
            default: begin
               do_commit = 1'b1;
               commit_b  = in;
            end
         endcase
      end else if (press[1]) begin
         if (state_q == MODE_SEL)
            mode_d = (mode_q == 3'd5) ? 3'd1 : mode_q + 3'd1;
         else if (state_q == OP_SEL)
            op_d = (op_q == op_last) ? 2'd0 : op_q + 2'd1;
      end else if (press[3] && state_q == MODE_SEL) begin
         count_d = '0;
      end

      // a full bank still returns to OP_SEL so the operator can exit or retry
      if (do_commit) begin
         state_d = OP_SEL;
         if (count_q < DEPTH_C) begin
            we       = 1'b1;
            count_d  = count_q + 1'b1;
            commit_d = 1'b1;
         end else begin
            reject_d = 1'b1;
         end
      end
   end

   assign wdat = {mode_q, op_q, commit_a, commit_b};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= MODE_SEL;
         mode_q     <= 3'd1;
         op_q       <= 2'd0;
         a_q        <= '0;
         count_q    <= '0;
         commit_q   <= 1'b0;
         reject_q   <= 1'b0;
         btn_q      <= '0;
         rd_entry_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         op_q       <= op_d;
         a_q        <= a_d;
         count_q    <= count_d;
         commit_q   <= commit_d;
         reject_q   <= reject_d;
         btn_q      <= btn_now;
         rd_entry_q <= ({1'b0, rd_idx} < count_q) ? bank_q[rd_idx] : '0;
      end
   end

   // bank storage carries no reset; count gates visibility of stale entries
   always_ff @(posedge clk) begin
      if (we) bank_q[count_q[IDX_W-1:0]] <= wdat;
   end

   assign rd_entry = rd_entry_q;
   assign count    = count_q;
   assign full     = (count_q == DEPTH_C);
   assign state    = state_q;
   assign mode_o   = mode_q;
   assign op_o     = op_q;
   assign prompt   = (state_q == ENTER_A) ? 2'b01 : (state_q == ENTER_B) ? 2'b10 : 2'b00;
   assign commit   = commit_q;
   assign reject   = reject_q;

endmodule

// File: tb/tb_competition_question_bank.sv
// Bench for competition_question_bank: behavioural model plus read-back scoreboard.
module tb_competition_question_bank;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 16;
   localparam int IDX_W   = 4;
   localparam int ENTRY_W = 21;

   logic               clk = 1'b0;
   logic               reset;
   logic               confirm, select, exit_b, clr_bank;
   logic [DATA_W-1:0]  in_v;
   logic [IDX_W-1:0]   rd_idx;
   logic [ENTRY_W-1:0] rd_entry;
   logic [IDX_W:0]     count;
   logic               full, commit, reject;
   logic [1:0]         state, op_o, prompt;
   logic [2:0]         mode_o;

   competition_question_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .confirm(confirm), .select(select), .exit(exit_b),
      .clr_bank(clr_bank), .in(in_v), .rd_idx(rd_idx), .rd_entry(rd_entry),
      .count(count), .full(full), .state(state), .mode_o(mode_o), .op_o(op_o),
      .prompt(prompt), .commit(commit), .reject(reject)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [ENTRY_W-1:0] exp_q [$];

   logic [1:0]         st_m, op_m;
   logic [2:0]         mode_m;
   logic [DATA_W-1:0]  a_m;
   logic [IDX_W:0]     cnt_m;
   logic [ENTRY_W-1:0] bank_m [DEPTH];
   logic               c_m, r_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "/state"},  32'(state),  32'(st_m));
      chk({tag, "/mode"},   32'(mode_o), 32'(mode_m));
      chk({tag, "/op"},     32'(op_o),   32'(op_m));
      chk({tag, "/prompt"}, 32'(prompt), (st_m == 2'd2) ? 32'd1 : (st_m == 2'd3) ? 32'd2 : 32'd0);
      chk({tag, "/count"},  32'(count),  32'(cnt_m));
      chk({tag, "/full"},   32'(full),   32'(cnt_m == 5'(DEPTH)));
      chk({tag, "/commit"}, 32'(commit), 32'(c_m));
      chk({tag, "/reject"}, 32'(reject), 32'(r_m));
   endtask

   task automatic model_reset();
      st_m = 2'd0; mode_m = 3'd1; op_m = 2'd0; cnt_m = '0; c_m = 1'b0; r_m = 1'b0;
   endtask

   task automatic model_commit(input logic [DATA_W-1:0] b);
      st_m = 2'd1;
      if (cnt_m < 5'(DEPTH)) begin
         bank_m[cnt_m[IDX_W-1:0]] = {mode_m, op_m, a_m, b};
         cnt_m = cnt_m + 1'b1;
         c_m = 1'b1;
      end else begin
         r_m = 1'b1;
      end
   endtask

   // m = {clr_bank, exit, select, confirm}; called at a negedge with all buttons low
   task automatic press(input string tag, input logic [3:0] m);
      logic [1:0] last;
      {clr_bank, exit_b, select, confirm} = m;
      c_m = 1'b0; r_m = 1'b0;
      last = (mode_m == 3'd1) ? 2'd2 : (mode_m == 3'd2) ? 2'd1 : 2'd3;
      if (m[2]) begin
         if (st_m != 2'd0) begin st_m = 2'd0; op_m = 2'd0; end
      end else if (m[0]) begin
         case (st_m)
            2'd0: begin op_m = 2'd0; st_m = 2'd1; end
            2'd1: st_m = 2'd2;
            2'd2: begin
               a_m = in_v;
               if (mode_m == 3'd1) model_commit(8'h00);
               else st_m = 2'd3;
            end
            default: model_commit(in_v);
         endcase
      end else if (m[1]) begin
         if (st_m == 2'd0) mode_m = (mode_m == 3'd5) ? 3'd1 : mode_m + 3'd1;
         else if (st_m == 2'd1) op_m = (op_m == last) ? 2'd0 : op_m + 2'd1;
      end else if (m[3] && st_m == 2'd0) begin
         cnt_m = '0;
      end
      @(negedge clk);
      check_outs(tag);
      {clr_bank, exit_b, select, confirm} = 4'b0000;
      c_m = 1'b0; r_m = 1'b0;
      @(negedge clk);
      chk({tag, "/pulse_end"}, {30'd0, commit, reject}, 32'd0);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         rd_idx = IDX_W'(i);
         exp_q.push_back((i < int'(cnt_m)) ? bank_m[i] : '0);
         @(negedge clk);
         chk($sformatf("%s/rd%0d", tag, i), 32'(rd_entry), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic enter_two(input string tag, input logic [7:0] a, input logic [7:0] b);
      press({tag, "/toA"}, 4'b0001);
      in_v = a;
      press({tag, "/a"}, 4'b0001);
      in_v = b;
      press({tag, "/b"}, 4'b0001);
   endtask

   initial begin
      reset = 1'b1;
      {clr_bank, exit_b, select, confirm} = 4'b0000;
      in_v = '0; rd_idx = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outs("reset");
      chk("reset/rd", 32'(rd_entry), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         press("modecyc", 4'b0010);
         chk("modecyc/step", 32'(mode_o), 32'((i + 1) % 5 + 1));
      end
      press("selconf", 4'b0011);
      chk("selconf/opsel", 32'(state), 32'd1);
      press("exit1", 4'b0100);

      press("m1/conf", 4'b0001);
      press("m1/sel1", 4'b0010);
      press("m1/sel2", 4'b0010);
      press("m1/toA", 4'b0001);
      in_v = 8'hA5;
      press("m1/commit", 4'b0001);
      rd_idx = '0;
      exp_q.push_back({3'd1, 2'd2, 8'hA5, 8'h00});
      @(negedge clk);
      chk("m1/rd0", 32'(rd_entry), 32'(exp_q.pop_front()));

      press("m2/exit", 4'b0100);
      press("m2/sel", 4'b0010);
      press("m2/conf", 4'b0001);
      press("m2/op1", 4'b0010);
      press("m2/op0", 4'b0010);
      enter_two("m2", 8'h12, 8'h34);
      read_all("m2");

      while (cnt_m < 5'(DEPTH)) begin
         if ($urandom_range(0, 1) == 1) press("fill/sel", 4'b0010);
         enter_two("fill", 8'($urandom), 8'($urandom));
      end
      enter_two("rej", 8'h5A, 8'hC3);
      read_all("full");

      press("ex/toA", 4'b0001);
      in_v = 8'h77;
      press("ex/a", 4'b0001);
      press("ex/exitB", 4'b0100);
      press("ex/conf", 4'b0001);
      press("ex/clr_ign", 4'b1000);
      press("ex/exit", 4'b0100);
      press("ex/clr", 4'b1000);
      read_all("clr");

      press("rst/conf", 4'b0001);
      for (int i = 0; i < 3; i++) enter_two("rst", 8'(i + 1), 8'(i + 8'h40));
      press("rst/toA", 4'b0001);
      in_v = 8'h99;
      press("rst/a", 4'b0001);
      chk("rst/inB", 32'(state), 32'd3);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_outs("async");
      chk("async/rd", 32'(rd_entry), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      read_all("postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
